// File: rtl/serial_sub.sv
// Bit-serial two's-complement subtractor: D = A - B - Bin, one bit per clock, LSB first.
// Optional signed-overflow output is enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] aSh_q, aSh_d;
  logic [WIDTH-1:0] bSh_q, bSh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] dOut_q, dOut_d;
  logic             bout_q, bout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bitD, brNext;
`ifdef SERIAL_SUB_OVF_EN
  logic             aSign_q, aSign_d;
  logic             bSign_q, bSign_d;
  logic             ovf_q, ovf_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      aSh_q   <= '0;
      bSh_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      dOut_q  <= '0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      aSign_q <= 1'b0;
      bSign_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      aSh_q   <= aSh_d;
      bSh_q   <= bSh_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      dOut_q  <= dOut_d;
      bout_q  <= bout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIAL_SUB_OVF_EN
      aSign_q <= aSign_d;
      bSign_q <= bSign_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Shared full-subtractor cell operating on the current LSBs.
  assign bitD   = aSh_q[0] ^ bSh_q[0] ^ br_q;
  assign brNext = (~aSh_q[0] & bSh_q[0]) | (~aSh_q[0] & br_q) | (bSh_q[0] & br_q);

  always_comb begin
    state_d = state_q;
    aSh_d   = aSh_q;
    bSh_d   = bSh_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    dOut_d  = dOut_q;
    bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    aSign_d = aSign_q;
    bSign_d = bSign_q;
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          aSh_d   = A;
          bSh_d   = B;
          br_d    = Bin;
          cnt_d   = '0;
          res_d   = '0;
`ifdef SERIAL_SUB_OVF_EN
          aSign_d = A[WIDTH-1];
          bSign_d = B[WIDTH-1];
`endif
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        aSh_d = {1'b0, aSh_q[WIDTH-1:1]};
        bSh_d = {1'b0, bSh_q[WIDTH-1:1]};
        res_d = {bitD, res_q[WIDTH-1:1]};
        br_d  = brNext;
        cnt_d = cnt_q + CW'(1);
        // Visible result only changes on the final bit, so no partial values leak out.
        if (cnt_q == LAST) begin
          state_d = DONE;
          dOut_d  = {bitD, res_q[WIDTH-1:1]};
          bout_d  = brNext;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d   = (aSign_q != bSign_q) && (bitD != aSign_q);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  assign busy = busy_q;
  assign done = done_q;
  assign D    = dOut_q;
  assign Bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub.sv
// Directed self-checking bench for serial_sub (WIDTH=4); checks ovf when SERIAL_SUB_OVF_EN is defined.
module tb_serial_sub;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] A, B;
  logic             Bin;
  logic             busy, done;
  logic [WIDTH-1:0] D;
  logic             Bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  int assertions = 0;
  int failures   = 0;

  serial_sub #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A    (A),
    .B    (B),
    .Bin  (Bin),
    .busy (busy),
    .done (done),
    .D    (D),
    .Bout (Bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf  (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertions++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic bin, input logic st);
    A     = a;
    B     = b;
    Bin   = bin;
    start = st;
  endtask

  // Pulses start for one cycle, then waits (bounded) for done and checks latency and result.
  task automatic runOp(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic bin, input logic [WIDTH-1:0] expD, input logic expBout);
    int cycles;
    applyStimulus(a, b, bin, 1'b1);
    @(negedge clk);
    start  = 1'b0;
    cycles = 1;
    while (!done && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput({tag, "_latency"}, cycles, WIDTH + 1);
    checkOutput({tag, "_D"}, D, expD);
    checkOutput({tag, "_Bout"}, Bout, expBout);
  endtask

  initial begin
    int cycles;
    applyStimulus('0, '0, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_D", D, 0);
    checkOutput("reset_Bout", Bout, 0);

    // Basic 9 - 3: busy in cycles 1..4, done in cycle 5
    applyStimulus(4'd9, 4'd3, 1'b0, 1'b1);
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      checkOutput($sformatf("basic_busy_c%0d", i), busy, 1);
      checkOutput($sformatf("basic_done_c%0d", i), done, 0);
      @(negedge clk);
    end
    checkOutput("basic_done_c5", done, 1);
    checkOutput("basic_busy_c5", busy, 0);
    checkOutput("basic_D", D, 4'h6);
    checkOutput("basic_Bout", Bout, 0);
    @(negedge clk);
    checkOutput("basic_done_pulse_end", done, 0);
    checkOutput("basic_D_hold", D, 4'h6);

    runOp("borrow_3m9", 4'd3, 4'd9, 1'b0, 4'hA, 1'b1);
    runOp("zero_m_bin", 4'd0, 4'd0, 1'b1, 4'hF, 1'b1);
    runOp("equal", 4'd5, 4'd5, 1'b0, 4'h0, 1'b0);
    runOp("max_m_0", 4'hF, 4'd0, 1'b0, 4'hF, 1'b0);
    runOp("0_m_15_m1", 4'd0, 4'hF, 1'b1, 4'h0, 1'b1);

    // Start during RUN must be ignored
    @(negedge clk);
    applyStimulus(4'd9, 4'd3, 1'b0, 1'b1);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    applyStimulus(4'd1, 4'd1, 1'b0, 1'b1);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checkOutput("ignore_busy_c4", busy, 1);
    @(negedge clk);
    checkOutput("ignore_done_c5", done, 1);
    checkOutput("ignore_D", D, 4'h6);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("ignore_nodone_%0d", i), done, 0);
      checkOutput($sformatf("ignore_idle_%0d", i), busy, 0);
      checkOutput($sformatf("ignore_Dhold_%0d", i), D, 4'h6);
    end

    // Reset during the second RUN cycle abandons the operation
    applyStimulus(4'hF, 4'd1, 1'b0, 1'b1);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midreset_busy", busy, 0);
    checkOutput("midreset_done", done, 0);
    checkOutput("midreset_D", D, 0);
    checkOutput("midreset_Bout", Bout, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput($sformatf("midreset_nodone_%0d", i), done, 0);
    end

    // Back-to-back: start held high, second operands accepted in DONE
    applyStimulus(4'd8, 4'd2, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    A = 4'd2;
    B = 4'd8;
    cycles = 2;
    while (!done && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("b2b_first_latency", cycles, WIDTH + 1);
    checkOutput("b2b_first_D", D, 4'h6);
    checkOutput("b2b_first_Bout", Bout, 0);
    @(negedge clk);
    start  = 1'b0;
    cycles = 1;
    while (!done && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("b2b_spacing", cycles, WIDTH + 1);
    checkOutput("b2b_second_D", D, 4'hA);
    checkOutput("b2b_second_Bout", Bout, 1);

`ifdef SERIAL_SUB_OVF_EN
    runOp("ovf_7m_neg1", 4'd7, 4'hF, 1'b0, 4'h8, 1'b1);
    checkOutput("ovf_set", ovf, 1);
    runOp("ovf_4m2", 4'd4, 4'd2, 1'b0, 4'h2, 1'b0);
    checkOutput("ovf_clear", ovf, 0);
`endif

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
